// File: rtl/bintree_shift_engine.sv
// Sequential lane-shift engine: moves NUM_LANES words by shift_amt lanes as binary hops of 2^k,
// one bit of the amount per cycle. Supports zero-fill, edge-fill and rotate; spill captures leavers.
module bintree_shift_engine #(
  parameter int NUM_LANES   = 8,
  parameter int WORD_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            dir,
  input  logic [1:0]                      mode,
  input  logic [SHIFT_WIDTH-1:0]          shift_amt,
  input  logic [NUM_LANES*WORD_WIDTH-1:0] data_in,
  input  logic [NUM_LANES*WORD_WIDTH-1:0] edge_in,
  output logic [NUM_LANES*WORD_WIDTH-1:0] data_out,
  output logic [NUM_LANES*WORD_WIDTH-1:0] spill_out,
  output logic                            busy,
  output logic                            done
);

  localparam int NW = NUM_LANES * WORD_WIDTH;
  localparam int CW = 3 * NW;
  localparam int KW = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [NW-1:0]          d_q, d_d;
  logic [NW-1:0]          e_q, e_d;
  logic [NW-1:0]          s_q, s_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   dir_q, dir_d;
  logic [1:0]             mode_q, mode_d;
  logic [SHIFT_WIDTH-1:0] amt_q, amt_d;
  logic                   done_q, done_d;

  logic [NW-1:0] hop_d [SHIFT_WIDTH];
  logic [NW-1:0] hop_e [SHIFT_WIDTH];
  logic [NW-1:0] hop_s [SHIFT_WIDTH];

  // One precomputed hop per bit position; the active one is picked by k_q.
  for (genvar g = 0; g < SHIFT_WIDTH; g++) begin : g_hop
    localparam longint unsigned H   = 64'd1 << g;
    localparam int unsigned     ROT = int'(H % NUM_LANES);

    logic [CW-1:0] ch_up, ch_dn, ch_up_s, ch_dn_s;
    logic [NW-1:0] rot_up, rot_dn;
    logic [NW-1:0] hd, he, hs;

    assign ch_up = {s_q, d_q, e_q};
    assign ch_dn = {e_q, d_q, s_q};

    if (H >= 3 * NUM_LANES) begin : g_far
      assign ch_up_s = '0;
      assign ch_dn_s = '0;
    end else begin : g_near
      assign ch_up_s = ch_up << (int'(H) * WORD_WIDTH);
      assign ch_dn_s = ch_dn >> (int'(H) * WORD_WIDTH);
    end

    always_comb begin
      rot_up = '0;
      rot_dn = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        rot_up[i*WORD_WIDTH +: WORD_WIDTH] =
          d_q[((i + NUM_LANES - ROT) % NUM_LANES)*WORD_WIDTH +: WORD_WIDTH];
        rot_dn[i*WORD_WIDTH +: WORD_WIDTH] =
          d_q[((i + ROT) % NUM_LANES)*WORD_WIDTH +: WORD_WIDTH];
      end
    end

    always_comb begin
      hd = d_q;
      he = e_q;
      hs = s_q;
      if (mode_q == 2'b10) begin
        hd = dir_q ? rot_dn : rot_up;
      end else if (!dir_q) begin
        he = ch_up_s[0 +: NW];
        hd = ch_up_s[NW +: NW];
        hs = ch_up_s[2*NW +: NW];
      end else begin
        hs = ch_dn_s[0 +: NW];
        hd = ch_dn_s[NW +: NW];
        he = ch_dn_s[2*NW +: NW];
      end
    end

    assign hop_d[g] = hd;
    assign hop_e[g] = he;
    assign hop_s[g] = hs;
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    e_d     = e_q;
    s_d     = s_q;
    k_d     = k_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    amt_d   = amt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          d_d     = data_in;
          e_d     = (mode == 2'b01 || mode == 2'b10) ? edge_in : '0;
          s_d     = '0;
          dir_d   = dir;
          mode_d  = mode;
          amt_d   = shift_amt;
          k_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (amt_q[k_q]) begin
          d_d = hop_d[k_q];
          e_d = hop_e[k_q];
          s_d = hop_s[k_q];
        end
        k_d = k_q + KW'(1);
        if (k_q == KW'(SHIFT_WIDTH - 1)) begin
          k_d     = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      e_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      dir_q   <= 1'b0;
      mode_q  <= '0;
      amt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      e_q     <= e_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      done_q  <= done_d;
    end
  end

  assign data_out  = d_q;
  assign spill_out = s_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;

endmodule

// File: tb/tb_bintree_shift_engine.sv
// Bench for bintree_shift_engine (N=4, W=8, SHIFT_WIDTH=3): directed cases plus random ops
// compared against a net-shift reference model.
module tb_bintree_shift_engine;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          dir;
  logic [1:0]    mode;
  logic [SW-1:0] shift_amt;
  logic [N*W-1:0] data_in, edge_in, data_out, spill_out;
  logic          busy, done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] DIN = 32'h44332211;
  localparam logic [31:0] EIN = 32'hA3A2A1A0;

  bintree_shift_engine #(
    .NUM_LANES  (N),
    .WORD_WIDTH (W),
    .SHIFT_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .mode     (mode),
    .shift_amt(shift_amt),
    .data_in  (data_in),
    .edge_in  (edge_in),
    .data_out (data_out),
    .spill_out(spill_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Net effect of a whole operation: one shift of the 3N-word chain, or a rotate mod N.
  function automatic void model(input logic d, input logic [1:0] m, input int amt,
                                input logic [31:0] din, input logic [31:0] ein,
                                output logic [31:0] dx, output logic [31:0] sx);
    logic [7:0] ch [12];
    logic [7:0] nw [12];
    int src;
    dx = '0;
    sx = '0;
    if (m == 2'b10) begin
      for (int i = 0; i < N; i++) begin
        src = d ? (i + amt) % N : (((i - amt) % N) + N) % N;
        dx[i*8 +: 8] = din[src*8 +: 8];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        ch[i]     = (!d && m == 2'b01) ? ein[i*8 +: 8] : 8'h00;
        ch[4 + i] = din[i*8 +: 8];
        ch[8 + i] = (d && m == 2'b01) ? ein[i*8 +: 8] : 8'h00;
      end
      for (int j = 0; j < 3 * N; j++) begin
        src = d ? j + amt : j - amt;
        nw[j] = (src >= 0 && src < 3 * N) ? ch[src] : 8'h00;
      end
      for (int i = 0; i < N; i++) begin
        dx[i*8 +: 8] = nw[4 + i];
        sx[i*8 +: 8] = d ? nw[i] : nw[8 + i];
      end
    end
  endfunction

  // Issue one op and wait (bounded) for done; lat = edges from accept to done, -1 on timeout.
  task automatic run_op(input logic d, input logic [1:0] m, input logic [SW-1:0] a,
                        input logic [31:0] din, input logic [31:0] ein,
                        output int lat, output int busy_cyc, output bit overlap);
    dir = d; mode = m; shift_amt = a; data_in = din; edge_in = ein; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; busy_cyc = 0; overlap = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cyc++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = c - 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dir = 1'b0; mode = 2'b00; shift_amt = '0;
    data_in = '0; edge_in = '0;
    tick(); tick();
    total_cnt++; if (data_out !== 32'h0) $display("FAIL reset_data got %h exp %h", data_out, 32'h0); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h0) $display("FAIL reset_spill got %h exp %h", spill_out, 32'h0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_fill();
    int lat, bc; bit ov;
    run_op(1'b0, 2'b00, 3'd1, DIN, EIN, lat, bc, ov);
    total_cnt++; if (lat !== 3) $display("FAIL zero_latency got %0d exp 3", lat); else pass_cnt++;
    total_cnt++; if (bc !== 3) $display("FAIL zero_busy_cycles got %0d exp 3", bc); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL zero_busy_done_overlap got %b exp 0", ov); else pass_cnt++;
    total_cnt++; if (data_out !== 32'h33221100) $display("FAIL zero_data got %h exp %h", data_out, 32'h33221100); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h00000044) $display("FAIL zero_spill got %h exp %h", spill_out, 32'h00000044); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL zero_done_pulse_width got %b exp 0", done); else pass_cnt++;
  endtask

  task automatic test_edge_fill();
    int lat, bc; bit ov;
    run_op(1'b1, 2'b01, 3'd3, DIN, EIN, lat, bc, ov);
    total_cnt++; if (data_out !== 32'hA2A1A044) $display("FAIL edge_data got %h exp %h", data_out, 32'hA2A1A044); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h33221100) $display("FAIL edge_spill got %h exp %h", spill_out, 32'h33221100); else pass_cnt++;
    tick();
  endtask

  task automatic test_rotate();
    int lat, bc; bit ov;
    run_op(1'b0, 2'b10, 3'd5, DIN, EIN, lat, bc, ov);
    total_cnt++; if (data_out !== 32'h33221144) $display("FAIL rot_d0_data got %h exp %h", data_out, 32'h33221144); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h0) $display("FAIL rot_d0_spill got %h exp %h", spill_out, 32'h0); else pass_cnt++;
    tick();
    run_op(1'b1, 2'b10, 3'd2, DIN, EIN, lat, bc, ov);
    total_cnt++; if (data_out !== 32'h22114433) $display("FAIL rot_d1_data got %h exp %h", data_out, 32'h22114433); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h0) $display("FAIL rot_d1_spill got %h exp %h", spill_out, 32'h0); else pass_cnt++;
    tick();
  endtask

  task automatic test_zero_far();
    int lat, bc; bit ov;
    run_op(1'b0, 2'b00, 3'd7, DIN, EIN, lat, bc, ov);
    total_cnt++; if (data_out !== 32'h0) $display("FAIL far_data got %h exp %h", data_out, 32'h0); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h11000000) $display("FAIL far_spill got %h exp %h", spill_out, 32'h11000000); else pass_cnt++;
    tick();
  endtask

  task automatic test_ignore_and_abort();
    bit seen;
    int lat;
    // start pulsed mid-operation with different controls must be ignored
    dir = 1'b0; mode = 2'b00; shift_amt = 3'd1; data_in = DIN; edge_in = EIN; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dir = 1'b1; mode = 2'b10; shift_amt = 3'd6; data_in = 32'hDEADBEEF; edge_in = 32'h55AA55AA; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      if (done) begin lat = c; break; end
      tick();
    end
    total_cnt++; if (lat < 0) $display("FAIL ignore_done_timeout got none exp done"); else pass_cnt++;
    total_cnt++; if (data_out !== 32'h33221100) $display("FAIL ignore_data got %h exp %h", data_out, 32'h33221100); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h00000044) $display("FAIL ignore_spill got %h exp %h", spill_out, 32'h00000044); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL ignore_no_restart got busy=%b exp 0", busy); else pass_cnt++;

    // reset sampled at the edge ending the 2nd SHIFT cycle
    dir = 1'b1; mode = 2'b01; shift_amt = 3'd3; data_in = DIN; edge_in = EIN; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL abort_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (data_out !== 32'h0) $display("FAIL abort_data got %h exp %h", data_out, 32'h0); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h0) $display("FAIL abort_spill got %h exp %h", spill_out, 32'h0); else pass_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_no_done got activity=%b exp 0", seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit ov;
    run_op(1'b0, 2'b01, 3'd0, DIN, EIN, lat, bc, ov);
    total_cnt++; if (lat !== 3) $display("FAIL amt0_latency got %0d exp 3", lat); else pass_cnt++;
    total_cnt++; if (data_out !== DIN) $display("FAIL amt0_data got %h exp %h", data_out, DIN); else pass_cnt++;
    total_cnt++; if (spill_out !== 32'h0) $display("FAIL amt0_spill got %h exp %h", spill_out, 32'h0); else pass_cnt++;
    // still in the done cycle: the next start must be taken on the very next edge
    run_op(1'b1, 2'b10, 3'd2, DIN, EIN, lat, bc, ov);
    total_cnt++; if (lat !== 3) $display("FAIL b2b_latency got %0d exp 3", lat); else pass_cnt++;
    total_cnt++; if (bc !== 3) $display("FAIL b2b_busy_cycles got %0d exp 3", bc); else pass_cnt++;
    total_cnt++; if (data_out !== 32'h22114433) $display("FAIL b2b_data got %h exp %h", data_out, 32'h22114433); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    int lat, bc; bit ov;
    logic d; logic [1:0] m; logic [SW-1:0] a;
    logic [31:0] din, ein, dx, sx;
    for (int t = 0; t < 60; t++) begin
      d   = 1'($urandom_range(0, 1));
      m   = 2'($urandom_range(0, 3));
      a   = SW'($urandom_range(0, 7));
      din = $urandom;
      ein = $urandom;
      model(d, m, int'(a), din, ein, dx, sx);
      run_op(d, m, a, din, ein, lat, bc, ov);
      total_cnt++; if (lat !== 3 || ov !== 1'b0) $display("FAIL rand%0d_timing got lat=%0d ov=%b exp lat=3 ov=0", t, lat, ov); else pass_cnt++;
      total_cnt++; if (data_out !== dx) $display("FAIL rand%0d_data d=%b m=%0d a=%0d got %h exp %h", t, d, m, a, data_out, dx); else pass_cnt++;
      total_cnt++; if (spill_out !== sx) $display("FAIL rand%0d_spill d=%b m=%0d a=%0d got %h exp %h", t, d, m, a, spill_out, sx); else pass_cnt++;
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_edge_fill();
    test_rotate();
    test_zero_far();
    test_ignore_and_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
